// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared widths and the queued write-back entry type
package regfile_writeback_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: in-order queue with two write ports (port 0 ahead of port 1) and one read port
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_push0,
    input  wb_entry_t                            i_entry0,
    input  logic                                 i_push1,
    input  wb_entry_t                            i_entry1,
    input  logic                                 i_pop,
    output wb_entry_t                            o_head,
    output logic [CW-1:0]                        o_count,
    output logic [DEPTH-1:0]                     o_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_rd
);
    wb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  w_wr_ptr1;
    wb_entry_t      w_first;
    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    // A lone push always lands at the write pointer, whichever port it came from
    assign w_first   = i_push0 ? i_entry0 : i_entry1;
    always_ff @(posedge i_clk) begin
        if (i_push0 || i_push1) r_mem[r_wr_ptr] <= w_first;
        if (i_push0 && i_push1) r_mem[w_wr_ptr1] <= i_entry1;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] w_off;
        assign w_off      = AW'(i) - r_rd_ptr;
        assign o_valid[i] = {1'b0, w_off} < r_count;
        assign o_rd[i]    = r_mem[i].rd;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: queues ALU/load results and drives one register-file write per cycle
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_mem_valid,
    input  logic [REG_ADDR_W-1:0]   i_mem_rd,
    input  logic [XLEN-1:0]         i_mem_data,
    output logic                    o_mem_ready,
    input  logic                    i_alu_valid,
    input  logic [REG_ADDR_W-1:0]   i_alu_rd,
    input  logic [XLEN-1:0]         i_alu_data,
    output logic                    o_alu_ready,
    output logic                    o_write_enable,
    output logic [REG_ADDR_W-1:0]   o_rd,
    output logic [XLEN-1:0]         o_write_data,
    output logic [NUM_REGS-1:0]     o_pending
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0]                      w_count;
    logic [CW-1:0]                      w_free;
    wb_entry_t                          w_head;
    logic [DEPTH-1:0]                   w_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]   w_rd;
    logic                               w_mem_push;
    logic                               w_alu_push;
    logic                               w_pop;
    // Credit uses the pre-pop count; a load in flight reserves a slot ahead of the ALU
    assign w_free      = CW'(DEPTH) - w_count;
    assign o_mem_ready = !i_reset && w_free >= CW'(1);
    assign o_alu_ready = !i_reset && w_free >= (i_mem_valid ? CW'(2) : CW'(1));
    assign w_mem_push  = i_mem_valid && o_mem_ready && i_mem_rd != '0;
    assign w_alu_push  = i_alu_valid && o_alu_ready && i_alu_rd != '0;
    assign w_pop       = !i_reset && w_count != '0;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push0  (w_mem_push),
        .i_entry0 ('{rd: i_mem_rd, data: i_mem_data}),
        .i_push1  (w_alu_push),
        .i_entry1 ('{rd: i_alu_rd, data: i_alu_data}),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_valid  (w_valid),
        .o_rd     (w_rd)
    );
    assign o_write_enable = w_pop;
    assign o_rd           = w_pop ? w_head.rd : '0;
    assign o_write_data   = w_pop ? w_head.data : '0;
    always_comb begin
        o_pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_valid[i] && !i_reset) o_pending[w_rd[i]] = 1'b1;
        o_pending[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenario checks of the write-back queue
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_rd, alu_rd;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        write_enable;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [36:0] wlog [$];
    logic [31:0] rf [32];
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_mem_valid    (mem_valid),
        .i_mem_rd       (mem_rd),
        .i_mem_data     (mem_data),
        .o_mem_ready    (mem_ready),
        .i_alu_valid    (alu_valid),
        .i_alu_rd       (alu_rd),
        .i_alu_data     (alu_data),
        .o_alu_ready    (alu_ready),
        .o_write_enable (write_enable),
        .o_rd           (rd),
        .o_write_data   (write_data),
        .o_pending      (pending)
    );

    always @(posedge clk) begin
        if (write_enable) begin
            wlog.push_back({rd, write_data});
            rf[rd] <= write_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
        for (int c = 0; c < 2; c++) begin
            tick();
            vecs++;
            if ({mem_ready, alu_ready, write_enable} !== 3'b000) begin
                errs++;
                $display("FAIL reset_ctl cyc%0d: got rdy/we=%b want 000", c, {mem_ready, alu_ready, write_enable});
            end
            vecs++;
            if (pending !== 32'h0) begin
                errs++;
                $display("FAIL reset_pending cyc%0d: got %h want 0", c, pending);
            end
        end
        reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        vecs++;
        if ({mem_ready, alu_ready} !== 2'b11) begin
            errs++;
            $display("FAIL release_ready: got %b want 11", {mem_ready, alu_ready});
        end
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        vecs++;
        if (alu_ready !== 1'b1) begin
            errs++;
            $display("FAIL single_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        vecs++;
        if ({write_enable, rd, write_data, pending} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h20}) begin
            errs++;
            $display("FAIL single_write: got we=%b rd=%0d wd=%h pend=%h want 1/5/deadbeef/20",
                     write_enable, rd, write_data, pending);
        end
        tick();
        vecs++;
        if ({write_enable, pending} !== {1'b0, 32'h0}) begin
            errs++;
            $display("FAIL single_idle: got we=%b pend=%h want 0/0", write_enable, pending);
        end
    endtask

    task automatic test_dual_same_rd();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hFFFFFFFF;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd7;
        #1;
        vecs++;
        if ({mem_ready, alu_ready} !== 2'b11) begin
            errs++;
            $display("FAIL dual_ready: got %b want 11", {mem_ready, alu_ready});
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        vecs++;
        if ({write_enable, rd, write_data, pending} !== {1'b1, 5'd3, 32'hFFFFFFFF, 32'h8}) begin
            errs++;
            $display("FAIL dual_first: got we=%b rd=%0d wd=%h pend=%h want 1/3/ffffffff/8",
                     write_enable, rd, write_data, pending);
        end
        tick();
        vecs++;
        if ({write_enable, rd, write_data} !== {1'b1, 5'd3, 32'd7}) begin
            errs++;
            $display("FAIL dual_second: got we=%b rd=%0d wd=%h want 1/3/7", write_enable, rd, write_data);
        end
        tick();
        vecs++;
        if (write_enable !== 1'b0 || rf[3] !== 32'd7) begin
            errs++;
            $display("FAIL dual_final: got we=%b x3=%h want 0/7", write_enable, rf[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] exp [9];
        int base;
        exp = '{{5'd1, 32'h1000}, {5'd10, 32'h2000}, {5'd2, 32'h1001}, {5'd11, 32'h2001},
                {5'd3, 32'h1002}, {5'd4, 32'h1003}, {5'd5, 32'h1004}, {5'd6, 32'h1005},
                {5'd12, 32'h2002}};
        base = wlog.size();
        for (int c = 0; c < 6; c++) begin
            mem_valid = 1'b1; mem_rd = 5'(c + 1); mem_data = 32'h1000 + 32'(c);
            alu_valid = 1'b1; alu_rd = 5'(10 + (c < 2 ? c : 2)); alu_data = 32'h2000 + 32'(c < 2 ? c : 2);
            #1;
            vecs++;
            if ({mem_ready, alu_ready} !== {1'b1, c < 2}) begin
                errs++;
                $display("FAIL b2b_ready cyc%0d: got %b want %b", c, {mem_ready, alu_ready}, {1'b1, c < 2});
            end
            tick();
            if (c == 0) begin
                vecs++;
                if (pending !== 32'h402) begin
                    errs++;
                    $display("FAIL b2b_pending: got %h want 402", pending);
                end
            end
        end
        mem_valid = 1'b0;
        #1;
        vecs++;
        if (alu_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_alu_after: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        vecs++;
        if (wlog.size() - base !== 9) begin
            errs++;
            $display("FAIL b2b_count: got %0d writes want 9", wlog.size() - base);
        end
        for (int i = 0; i < 9; i++) begin
            if (base + i < wlog.size()) begin
                vecs++;
                if (wlog[base + i] !== exp[i]) begin
                    errs++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, wlog[base + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1;
        vecs++;
        if (alu_ready !== 1'b1) begin
            errs++;
            $display("FAIL x0_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        vecs++;
        if ({write_enable, pending} !== {1'b0, 32'h0}) begin
            errs++;
            $display("FAIL x0_discard: got we=%b pend=%h want 0/0", write_enable, pending);
        end
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        vecs++;
        if ({write_enable, rd, write_data, pending} !== {1'b1, 5'd9, 32'h99, 32'h200}) begin
            errs++;
            $display("FAIL x0_mix_first: got we=%b rd=%0d wd=%h pend=%h want 1/9/99/200",
                     write_enable, rd, write_data, pending);
        end
        tick();
        vecs++;
        if (write_enable !== 1'b0) begin
            errs++;
            $display("FAIL x0_mix_after: got we=%b want 0", write_enable);
        end
    endtask

    task automatic test_reset_midburst();
        int base;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        tick();
        mem_rd = 5'd9; mem_data = 32'h99;
        alu_rd = 5'd10; alu_data = 32'hAA;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0; reset = 1'b1;
        base = wlog.size();
        #1;
        vecs++;
        if ({write_enable, mem_ready, alu_ready, pending} !== {3'b000, 32'h0}) begin
            errs++;
            $display("FAIL rst_mid_hold: got we/rdy=%b pend=%h want 000/0",
                     {write_enable, mem_ready, alu_ready}, pending);
        end
        tick();
        reset = 1'b0;
        #1;
        vecs++;
        if ({write_enable, pending} !== {1'b0, 32'h0}) begin
            errs++;
            $display("FAIL rst_mid_after: got we=%b pend=%h want 0/0", write_enable, pending);
        end
        for (int c = 0; c < 3; c++) tick();
        vecs++;
        if (wlog.size() !== base || base == 0 || wlog[base - 1] !== {5'd7, 32'h77}) begin
            errs++;
            $display("FAIL rst_mid_log: got %0d new writes, last=%h want 0 new, last=%h",
                     wlog.size() - base, base == 0 ? 37'h0 : wlog[base - 1], {5'd7, 32'h77});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_same_rd();
        test_back_to_back();
        test_x0();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
